// File: rtl/div_pkg.sv
// Shared types and constants for the integer divide unit.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, subtract if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH:0]   o_acc,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_dsr_ext;

  assign w_shift   = {i_acc, i_dvd_msb};
  assign w_dsr_ext = {2'b00, i_dsr};

  // Compare the shifted partial remainder against the divisor and restore when it does not fit.
  always_comb begin
    o_qbit = 1'b0;
    o_acc  = w_shift[WIDTH:0];
    if (w_shift >= w_dsr_ext) begin
      o_qbit = 1'b1;
      o_acc  = (WIDTH+1)'(w_shift - w_dsr_ext);
    end
  end

endmodule

// File: rtl/div_responder.sv
// Multi-cycle DIV/DIVU responder: request handshake in, quotient/remainder handshake out.
module div_responder
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH:0]   w_acc_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_accept  = (r_state == IDLE) && req_valid && !flush;
  assign w_dvd_neg = req_signed && dividend[WIDTH-1];
  assign w_dsr_neg = req_signed && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dsr_mag = w_dsr_neg ? -divisor : divisor;

  // Quotient bits shift into the low end of r_dvd as dividend bits leave the top.
  assign w_q = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_r = w_acc_next[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_dsr     (r_dsr),
    .o_acc     (w_acc_next),
    .o_qbit    (w_qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_state_next = DONE;
      DONE:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  // Operand latch, iteration datapath and result registers; results only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_div_zero <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (divisor == '0) begin
              r_lo       <= DIV_ZERO_QUOT;
              r_hi       <= dividend;
              r_div_zero <= 1'b1;
            end else begin
              r_acc   <= '0;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_dvd   <= w_dvd_mag;
              r_dsr   <= w_dsr_mag;
              r_q_neg <= w_dvd_neg ^ w_dsr_neg;
              r_r_neg <= w_dvd_neg;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_dvd <= w_q;
          if (r_cnt == '0) begin
            r_lo       <= r_q_neg ? -w_q : w_q;
            r_hi       <= r_r_neg ? -w_r : w_r;
            r_div_zero <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign lo         = r_lo;
  assign hi         = r_hi;
  assign div_zero   = r_div_zero;

endmodule

// File: tb/tb_div_responder.sv
// Directed self-checking bench for div_responder.
module tb_div_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        div_zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .lo         (lo),
    .hi         (hi),
    .div_zero   (div_zero),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".lo"}, lo, 32'd0);
    chk({tag, ".hi"}, hi, 32'd0);
    chk({tag, ".div_zero"}, 32'(div_zero), 32'd0);
  endtask

  // Issue one request; returns after the accept edge, sampled on the following negedge.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid  = 1'b1;
    req_signed = sgn;
    dividend   = a;
    divisor    = b;
    @(negedge clk);
    req_valid  = 1'b0;
    dividend   = 32'hDEAD_BEEF;
    divisor    = 32'h0BAD_F00D;
  endtask

  // Full transaction: accept, wait for the response, check it, drain it after hold cycles of backpressure.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_dz, input int hold);
    int lat;
    issue(sgn, a, b);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".lo"}, lo, exp_lo);
    chk({tag, ".hi"}, hi, exp_hi);
    chk({tag, ".div_zero"}, 32'(div_zero), 32'(exp_dz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".hold_lo"}, lo, exp_lo);
      chk({tag, ".hold_hi"}, hi, exp_hi);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".drained_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".drained_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    run_div("u100_7",    1'b0, 32'd100,       32'd7,         32, 32'd14,        32'd2,         1'b0, 0);
    run_div("s-7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    run_div("s7_-2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32, 32'hFFFF_FFFD, 32'd1,         1'b0, 0);
    run_div("s_dz",      1'b1, 32'h1234,      32'd0,         0,  32'hFFFF_FFFF, 32'h1234,      1'b1, 0);
    run_div("u_dz",      1'b0, 32'h1234,      32'd0,         0,  32'hFFFF_FFFF, 32'h1234,      1'b1, 0);
    run_div("s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h8000_0000, 32'd0,         1'b0, 0);
    run_div("u_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32, 32'hFFFF_FFFF, 32'd0,         1'b0, 0);
    run_div("bp_u100_7", 1'b0, 32'd100,       32'd7,         32, 32'd14,        32'd2,         1'b0, 5);

    // Flush ten cycles into 50/3: previous 14/2 result must survive and no response appears.
    issue(1'b0, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    chk("flush.pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.req_ready", 32'(req_ready), 32'd1);
    chk("flush.resp_valid", 32'(resp_valid), 32'd0);
    chk("flush.lo", lo, 32'd14);
    chk("flush.hi", hi, 32'd2);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (resp_valid || busy) seen++;
      end
      chk("flush.no_resp", 32'(seen), 32'd0);
    end

    // Reset mid-CALC returns every output to its reset value.
    issue(1'b0, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("rst_mid");

    // Flush together with req_valid in IDLE blocks the accept.
    @(negedge clk);
    req_valid = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd3;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flush_idle.busy", 32'(busy), 32'd0);
    chk("flush_idle.req_ready", 32'(req_ready), 32'd1);
    chk("flush_idle.resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("flush_idle.busy_later", 32'(busy), 32'd0);

    run_div("u50_3", 1'b0, 32'd50, 32'd3, 32, 32'd16, 32'd2, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
